// File: rtl/sbram_arbiter_if.sv
// Request/response and RAM-side bus of the two-port single-bank RAM arbiter.
// slave = arbiter side, master = requesters plus RAM.
`timescale 1ns/1ps
interface sbram_arbiter_if;
  logic        i_a_valid;
  logic        i_a_we;
  logic [7:0]  i_a_addr;
  logic [15:0] i_a_wdata;
  logic [15:0] i_a_mask;
  logic        o_a_ready;
  logic        o_a_rvalid;
  logic [15:0] o_a_rdata;

  logic        i_b_valid;
  logic        i_b_we;
  logic [7:0]  i_b_addr;
  logic [15:0] i_b_wdata;
  logic [15:0] i_b_mask;
  logic        o_b_ready;
  logic        o_b_rvalid;
  logic [15:0] o_b_rdata;

  logic        o_ram_re;
  logic [7:0]  o_ram_raddr;
  logic        o_ram_we;
  logic [7:0]  o_ram_waddr;
  logic [15:0] o_ram_wdata;
  logic [15:0] o_ram_mask;
  logic [15:0] i_ram_rdata;

  modport slave (
    input  i_a_valid, i_a_we, i_a_addr, i_a_wdata, i_a_mask,
    output o_a_ready, o_a_rvalid, o_a_rdata,
    input  i_b_valid, i_b_we, i_b_addr, i_b_wdata, i_b_mask,
    output o_b_ready, o_b_rvalid, o_b_rdata,
    output o_ram_re, o_ram_raddr, o_ram_we, o_ram_waddr, o_ram_wdata, o_ram_mask,
    input  i_ram_rdata
  );

  modport master (
    output i_a_valid, i_a_we, i_a_addr, i_a_wdata, i_a_mask,
    input  o_a_ready, o_a_rvalid, o_a_rdata,
    output i_b_valid, i_b_we, i_b_addr, i_b_wdata, i_b_mask,
    input  o_b_ready, o_b_rvalid, o_b_rdata,
    input  o_ram_re, o_ram_raddr, o_ram_we, o_ram_waddr, o_ram_wdata, o_ram_mask,
    output i_ram_rdata
  );
endinterface

// File: rtl/sbram_arbiter.sv
// Two-requester arbiter in front of a 256x16 block RAM with 1-cycle registered read.
// Optional macro SBRAM_ARB_RR_EN: round-robin on contention instead of fixed A priority.
`timescale 1ns/1ps
module sbram_arbiter #(
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  sbram_arbiter_if.slave  bus,
  output logic            o_busy,
  output logic [0:0]      o_dbg_state
);
  // Handshake: a request transfers in the cycle where valid and ready are both
  // high; ready is combinational and never raised while valid is low.

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  logic [0:0]  state;
  logic [7:0]  cnt;
  logic        in_clear;
  logic        in_run;
  logic        grant_a;
  logic        grant_b;
  logic        granted;
  logic        sel_we;
  logic [7:0]  sel_addr;
  logic [15:0] sel_wdata;
  logic [15:0] sel_mask;
  logic        rvalid_a;
  logic        rvalid_b;
  logic [15:0] hold_a;
  logic [15:0] hold_b;

  // Reset gates the combinational outputs so they drop as soon as reset asserts.
  assign in_clear = i_rst_n && (state == ST_CLEAR);
  assign in_run   = i_rst_n && (state == ST_RUN);

`ifdef SBRAM_ARB_RR_EN
  logic contend;
  logic rr_ptr;  // 1 means B is favoured on the next contended cycle

  assign contend = bus.i_a_valid && bus.i_b_valid;
  assign grant_a = in_run && bus.i_a_valid && (!bus.i_b_valid || !rr_ptr);
  assign grant_b = in_run && bus.i_b_valid && (!bus.i_a_valid || rr_ptr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr <= 1'b0;
    end else if (in_run && contend) begin
      rr_ptr <= grant_a;
    end
  end
`else
  assign grant_a = in_run && bus.i_a_valid;
  assign grant_b = in_run && bus.i_b_valid && !bus.i_a_valid;
`endif

  assign granted = grant_a || grant_b;

  always_comb begin
    sel_we    = bus.i_a_we;
    sel_addr  = bus.i_a_addr;
    sel_wdata = bus.i_a_wdata;
    sel_mask  = bus.i_a_mask;
    if (grant_b) begin
      sel_we    = bus.i_b_we;
      sel_addr  = bus.i_b_addr;
      sel_wdata = bus.i_b_wdata;
      sel_mask  = bus.i_b_mask;
    end
  end

  assign bus.o_a_ready   = grant_a;
  assign bus.o_b_ready   = grant_b;
  assign bus.o_ram_we    = in_clear || (granted && sel_we);
  assign bus.o_ram_re    = granted && !sel_we;
  assign bus.o_ram_raddr = sel_addr;
  assign bus.o_ram_waddr = in_clear ? cnt : sel_addr;
  assign bus.o_ram_wdata = in_clear ? 16'h0000 : sel_wdata;
  assign bus.o_ram_mask  = in_clear ? 16'h0000 : sel_mask;

  assign o_busy      = in_clear;
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_RESET;
      cnt   <= 8'h00;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + 8'h01;
      if (cnt == 8'hFF) begin
        state <= ST_RUN;
      end
    end
  end

  // Read data leaves the RAM one cycle after the grant; the last word is held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      hold_a   <= 16'h0000;
      hold_b   <= 16'h0000;
    end else begin
      rvalid_a <= grant_a && !bus.i_a_we;
      rvalid_b <= grant_b && !bus.i_b_we;
      if (rvalid_a) hold_a <= bus.i_ram_rdata;
      if (rvalid_b) hold_b <= bus.i_ram_rdata;
    end
  end

  assign bus.o_a_rvalid = rvalid_a;
  assign bus.o_b_rvalid = rvalid_b;
  assign bus.o_a_rdata  = rvalid_a ? bus.i_ram_rdata : hold_a;
  assign bus.o_b_rdata  = rvalid_b ? bus.i_ram_rdata : hold_b;
endmodule
